// File: rtl/qlf_carry_seq_pkg.sv
// Shared types and helpers for the byte-serial add/subtract sequencer.
// Used by qlf_rr_arb and qlf_carry8_seq.
package qlf_carry_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int SLICE_W = 8;

  function automatic int beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qlf_rr_arb.sv
// Combinational round-robin arbiter: search starts at ptr and wraps.
// The pointer register itself lives in the parent.
module qlf_rr_arb
  import qlf_carry_seq_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  logic [IDW:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = {1'b0, ptr} + (IDW+1)'(k);
      if (j >= (IDW+1)'(NUM_REQ))
        j = j - (IDW+1)'(NUM_REQ);
      if (!any && req[j[IDW-1:0]]) begin
        any              = 1'b1;
        gnt[j[IDW-1:0]]  = 1'b1;
        idx              = j[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/qlf_carry8_seq.sv
// Byte-serial add/subtract sequencer sharing one 8-bit carry slice.
// Optional flags (rsp_zero, rsp_ovf) under QLF_CARRY_SEQ_FLAGS_EN.
module qlf_carry8_seq
  import qlf_carry_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [id_w(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     busy
`ifdef QLF_CARRY_SEQ_FLAGS_EN
  ,
  output logic                     rsp_zero,
  output logic                     rsp_ovf
`endif
);

  localparam int BEATS = WIDTH / SLICE_W;
  localparam int BW    = beat_w(BEATS);
  localparam int IDW   = id_w(NUM_REQ);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry;
  logic [BW-1:0]      beat;
  logic [IDW-1:0]     ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gidx;
  logic               gany;
  logic               take;
  logic [IDW-1:0]     ptr_nxt;

  logic [SLICE_W-1:0] sa;
  logic [SLICE_W-1:0] sb;
  logic [SLICE_W-1:0] sp;
  logic [SLICE_W-1:0] ss;
  logic [SLICE_W:0]   c;
  logic [WIDTH-1:0]   sum_nxt;

  qlf_rr_arb #(
    .NUM_REQ(NUM_REQ),
    .IDW    (IDW)
  ) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(gidx),
    .any(gany)
  );

  // Grant is masked by reset so ready drops the instant reset asserts.
  assign req_ready = (state == IDLE && !reset && gany) ? gnt : '0;
  assign take      = |(req_valid & req_ready);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign ptr_nxt   = (gidx == IDW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;

  always_comb begin
    sa   = a_q[int'(beat)*SLICE_W +: SLICE_W];
    sb   = b_q[int'(beat)*SLICE_W +: SLICE_W];
    sp   = sa ^ sb;
    c    = '0;
    c[0] = carry;
    for (int i = 0; i < SLICE_W; i++)
      c[i+1] = sp[i] ? c[i] : sa[i];
    ss      = sp ^ c[SLICE_W-1:0];
    sum_nxt = rsp_sum;
    sum_nxt[int'(beat)*SLICE_W +: SLICE_W] = ss;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry    <= 1'b0;
      beat     <= '0;
      ptr      <= '0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
`ifdef QLF_CARRY_SEQ_FLAGS_EN
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            a_q    <= req_a[int'(gidx)*WIDTH +: WIDTH];
            b_q    <= req_b[int'(gidx)*WIDTH +: WIDTH]
                      ^ {WIDTH{req_sub[gidx]}};
            carry  <= req_sub[gidx];
            beat   <= '0;
            rsp_id <= gidx;
            ptr    <= ptr_nxt;
            state  <= RUN;
          end
        end
        RUN: begin
          rsp_sum <= sum_nxt;
          carry   <= c[SLICE_W];
          if (beat == BW'(BEATS-1)) begin
            rsp_cout <= c[SLICE_W];
`ifdef QLF_CARRY_SEQ_FLAGS_EN
            rsp_zero <= (sum_nxt == '0);
            rsp_ovf  <= c[SLICE_W-1] ^ c[SLICE_W];
`endif
            state    <= DONE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/qlf_carry8_seq.md
Name: qlf_carry8_seq

Overview:
- Multi-cycle add/subtract sequencer that time-shares one 8-bit carry-chain slice (generate/propagate per bit, registered carry between beats) among NUM_REQ requesters.
- Wide operands are processed one byte per cycle, least significant byte first. Carry-out of each beat is held in a flop and fed back as carry-in of the next beat.
- Sits in the qlf_k6n10f arithmetic support logic, where a wide $alu does not justify a full-length carry chain.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 8 and at least 16.
- NUM_REQ, 2, number of requesters; range 1..8.
- BEATS, WIDTH/8, derived (localparam); beats per operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at slice [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing as req_a.
- req_sub  in  NUM_REQ  1 = A-B, 0 = A+B.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumed.
- rsp_id  out  clog2(NUM_REQ) (min 1)  index of the granted requester.
- rsp_sum  out  WIDTH  result, modulo 2^WIDTH.
- rsp_cout  out  1  carry-out of MSB; for subtract, 1 means no borrow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- State machine, IDLE -> RUN -> DONE -> IDLE.
- Reset state: IDLE. Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0, carry flop=0, beat counter=0, round-robin pointer=0.
- IDLE:
  - req_ready is driven combinationally to a one-hot grant when any req_valid is high.
  - Grant is round-robin, starting search at pointer.
  - On the handshake edge: latch A, B XOR {WIDTH{sub}}, sub and id; carry flop <= sub; beat <= 0; pointer <= grant index + 1 (mod NUM_REQ); go to RUN.
- RUN:
  - Each cycle, compute byte[beat]: s = a_k ^ b_k, sum = s ^ {c[7:0],cin}, carry per bit = s ? cin : a.
  - Write sum into rsp_sum byte lane beat; carry flop <= bit-7 carry.
  - When beat == BEATS-1: rsp_cout <= final carry; go to DONE. Otherwise beat++.
- DONE:
  - rsp_valid=1 and rsp_sum, rsp_cout, rsp_id are stable.
  - On rsp_valid && rsp_ready: go to IDLE.
  - No request is accepted in DONE; the next grant happens at the earliest on the cycle after the response handshake.
- Latency: rsp_valid rises exactly BEATS cycles after the request handshake edge. Throughput is one operation per BEATS+2 cycles with rsp_ready held high.
- Requesters must hold req_a, req_b and req_sub stable while req_valid is high and not yet granted. Withdrawing req_valid before grant is legal.
- Asserting reset in RUN or DONE aborts the operation; no rsp_valid is produced.
- NUM_REQ=1: grant is req_valid[0], pointer is unused, and rsp_id=0.

Optional Feature:
- Macro: QLF_CARRY_SEQ_FLAGS_EN.
- When defined, two extra output ports are added:
  - rsp_zero (1 bit): rsp_sum == 0.
  - rsp_ovf (1 bit): signed overflow = carry into MSB XOR carry out of MSB, captured on the final beat.
- Both flags are valid with rsp_valid and reset to 0.
- When undefined, the ports and their logic are absent and all other behaviour is identical.

Decomposition:
- Package qlf_carry_seq_pkg holds:
  - state typedef enum {IDLE, RUN, DONE}.
  - localparam SLICE_W = 8.
  - function for the beat-count width.
- Sub-module qlf_rr_arb (NUM_REQ): req vector, pointer -> one-hot grant and encoded index. It is purely combinational; the pointer register stays in the parent.
- The 8-bit carry slice is coded inline in the parent.

Test Plan:
- WIDTH=32, r0 A=0xFFFFFFFF, B=0x00000001, add -> rsp_sum=0x00000000, rsp_cout=1, rsp_valid exactly 4 cycles after the handshake; with FLAGS_EN, zero=1, ovf=0.
- r1 A=5, B=7, sub -> rsp_sum=0xFFFFFFFE, rsp_cout=0, rsp_id=1; with FLAGS_EN, ovf=0. Then A=0x80000000, B=1, sub -> 0x7FFFFFFF, cout=1, ovf=1.
- Both requesters valid continuously after reset -> grant order r0, r1, r0, r1. The loser's req_ready stays 0 until the next IDLE.
- rsp_ready held low 10 cycles in DONE -> rsp_valid, sum and id stable; req_ready=0 throughout; accept resumes the cycle after rsp_ready=1.
- reset pulsed on beat 2 of RUN -> all outputs at reset values that cycle (asynchronously). The next request completes correctly with pointer=0.
- Random 1000 operations, random sub, random back-pressure -> sum and cout match a (WIDTH+1)-bit reference model; no request is lost or duplicated per id.
